// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared constants for the DMA reader scheduler: FSM encodings
// and the error codes reported by the reader and by the scheduler.
package painterengine_gpu_dma_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [2:0] ERR_OK           = 3'd0;
    localparam logic [2:0] ERR_ROUTER       = 3'd1;
    localparam logic [2:0] ERR_ADDRESS      = 3'd2;
    localparam logic [2:0] ERR_ADDR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_DATA_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_PROTOCOL     = 3'd5;
    localparam logic [2:0] ERR_WATCHDOG     = 3'd6;

endpackage

// File: rtl/painterengine_gpu_rr_arbiter4.sv
// Combinational 4-way round-robin picker: first set request
// searching upward from the pointer, wrapping modulo 4.
module painterengine_gpu_rr_arbiter4
    import painterengine_gpu_dma_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] pointer,
    output logic [3:0] grant,
    output logic [1:0] index,
    output logic       valid
);

    logic [1:0] cand;

    // Walk from the farthest offset down so the nearest one wins last.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = pointer + 2'(i);
            if (req[cand]) begin
                grant = 4'b0001 << cand;
                index = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/painterengine_gpu_dma_reader_scheduler.sv
// Shares one single-shot DMA reader among four requesters: grant,
// hold reader in reset with a stable router, release, await result.
module painterengine_gpu_dma_reader_scheduler
    import painterengine_gpu_dma_pkg::*;
#(
    parameter int RESET_CYCLES   = 2,
    parameter int WATCHDOG_WIDTH = 20
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    input  logic         i_wire_enable,
    input  logic [3:0]   i_wire_req,
    input  logic [127:0] i_wire_req_address,
    input  logic [127:0] i_wire_req_length,
    output logic [3:0]   o_wire_ack,
    output logic [3:0]   o_wire_done,
    output logic [3:0]   o_wire_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_busy,
    output logic         o_wire_reader_resetn,
    output logic [3:0]   o_wire_reader_router,
    output logic [127:0] o_wire_reader_address,
    output logic [127:0] o_wire_reader_length,
    input  logic         i_wire_reader_done,
    input  logic         i_wire_reader_error,
    input  logic [2:0]   i_wire_reader_error_type
);

    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic [1:0]              state;
    logic [1:0]              pointer;
    logic [1:0]              gidx;
    logic [CW-1:0]           counter;
    logic [WATCHDOG_WIDTH:0] watchdog;
    logic [WATCHDOG_WIDTH:0] watchdog_inc;

    logic [3:0]   arb_grant;
    logic [1:0]   arb_index;
    logic         arb_valid;
    logic [127:0] addr_sel;
    logic [127:0] len_sel;

    painterengine_gpu_rr_arbiter4 u_arb (
        .req     (i_wire_req),
        .pointer (pointer),
        .grant   (arb_grant),
        .index   (arb_index),
        .valid   (arb_valid)
    );

    always_comb begin
        addr_sel = '0;
        len_sel  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) begin
                addr_sel[k*32 +: 32] = i_wire_req_address[k*32 +: 32];
                len_sel[k*32 +: 32]  = i_wire_req_length[k*32 +: 32];
            end
        end
    end

    // Expiry is judged on the incremented count so the error pulse
    // lands exactly 2^WATCHDOG_WIDTH cycles after RUN entry.
    assign watchdog_inc = watchdog + 1'b1;

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state                 <= ST_IDLE;
            pointer               <= '0;
            gidx                  <= '0;
            counter               <= '0;
            watchdog              <= '0;
            o_wire_ack            <= '0;
            o_wire_done           <= '0;
            o_wire_error          <= '0;
            o_wire_error_type     <= ERR_OK;
            o_wire_busy           <= 1'b0;
            o_wire_reader_resetn  <= 1'b0;
            o_wire_reader_router  <= '0;
            o_wire_reader_address <= '0;
            o_wire_reader_length  <= '0;
        end else begin
            o_wire_ack   <= '0;
            o_wire_done  <= '0;
            o_wire_error <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (i_wire_enable && arb_valid) begin
                        state                 <= ST_LAUNCH;
                        o_wire_busy           <= 1'b1;
                        gidx                  <= arb_index;
                        o_wire_reader_router  <= arb_grant;
                        o_wire_reader_address <= addr_sel;
                        o_wire_reader_length  <= len_sel;
                        o_wire_ack            <= arb_grant;
                        counter               <= CW'(RESET_CYCLES - 1);
                    end
                end
                ST_LAUNCH: begin
                    if (counter == '0) begin
                        o_wire_reader_resetn <= 1'b1;
                        watchdog             <= '0;
                        state                <= ST_RUN;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                ST_RUN: begin
                    watchdog <= watchdog_inc;
                    if (i_wire_reader_error || i_wire_reader_done ||
                        watchdog_inc[WATCHDOG_WIDTH]) begin
                        state                 <= ST_FINISH;
                        o_wire_reader_resetn  <= 1'b0;
                        o_wire_reader_router  <= '0;
                        o_wire_reader_address <= '0;
                        o_wire_reader_length  <= '0;
                        if (i_wire_reader_error) begin
                            o_wire_error_type <= i_wire_reader_error_type;
                            o_wire_error      <= o_wire_reader_router;
                        end else if (i_wire_reader_done) begin
                            o_wire_done <= o_wire_reader_router;
                        end else begin
                            o_wire_error_type <= ERR_WATCHDOG;
                            o_wire_error      <= o_wire_reader_router;
                        end
                    end
                end
                ST_FINISH: begin
                    pointer     <= gidx + 2'd1;
                    state       <= ST_IDLE;
                    o_wire_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/painterengine_gpu_dma_reader_scheduler.md
Name: painterengine_gpu_dma_reader_scheduler

Overview:
- Sequencer and arbiter in front of painterengine_gpu_dma_reader, which runs one job per reset: it samples a one-hot router right after reset release, streams the data and then sits in done or error.
- This block shares that reader between 4 requesters using round-robin arbitration.
- For each job it latches the winner's address and length, holds the reader in reset while presenting a stable router, releases it, then waits for done or error.
- It reports a per-requester completion or error pulse and returns the reader to reset.

Parameters:
- RESET_CYCLES, 2, number of cycles the reader is held in reset with a valid router before release (minimum 1).
- WATCHDOG_WIDTH, 20, width of the RUN-state watchdog counter; it expires at 2^WATCHDOG_WIDTH cycles.

Ports:
- i_wire_clock  in  1  clock
- i_wire_resetn  in  1  asynchronous active-low reset
- i_wire_enable  in  1  grants are allowed only while high; a job already running always completes
- i_wire_req  in  4  per-requester level request; address and length must stay stable until ack
- i_wire_req_address  in  128  request address, 32 bits per requester, requester k at [k*32+:32]
- i_wire_req_length  in  128  request length in 32-bit words, same packing
- o_wire_ack  out  4  one-cycle pulse when the request is latched
- o_wire_done  out  4  one-cycle pulse when the job finishes successfully
- o_wire_error  out  4  one-cycle pulse when the job fails
- o_wire_error_type  out  3  error code of the last failed job (sticky)
- o_wire_busy  out  1  high in any state other than IDLE
- o_wire_reader_resetn  out  1  drives the reader's i_wire_resetn
- o_wire_reader_router  out  4  one-hot router to the reader
- o_wire_reader_address  out  128  reader address vector
- o_wire_reader_length  out  128  reader length vector
- i_wire_reader_done  in  1  reader o_wire_done
- i_wire_reader_error  in  1  reader o_wire_error
- i_wire_reader_error_type  in  3  reader o_wire_error_type

Behaviour:
- Reset is i_wire_resetn, asynchronous, active-low; the clock is i_wire_clock.
- During reset:
  - all outputs are 0, including o_wire_reader_resetn (reader held in reset);
  - the round-robin pointer is 0 and the state is IDLE.
- Reader data, valid and next signals connect directly between requesters and reader. The router stays constant from LAUNCH through RUN, so the reader's combinational data demux is stable.
- All outputs are registered.
- FSM: IDLE -> LAUNCH -> RUN -> FINISH -> IDLE.
- IDLE:
  - reader_resetn=0, router=0, address and length vectors are 0.
  - When i_wire_enable=1 and any req bit is set, at the clock edge:
    - grant g = first set bit searching from the pointer upward, mod 4;
    - latch address[g] and length[g] into slot g of the reader vectors, all other slots 0;
    - router = 1<<g;
    - o_wire_ack[g]=1 for the next cycle only;
    - counter = RESET_CYCLES-1; state -> LAUNCH.
- LAUNCH:
  - reader_resetn stays 0 while the counter decrements.
  - When the counter is 0: reader_resetn=1 on the next cycle, watchdog cleared, state -> RUN.
- RUN:
  - The watchdog increments every cycle.
  - Priority order: error > done > watchdog.
  - reader_error=1: error_type <= reader_error_type, error[g] pulses, state -> FINISH.
  - reader_done=1: done[g] pulses, state -> FINISH.
  - Watchdog MSB set (count 2^WATCHDOG_WIDTH reached): error_type <= 3'b110, error[g] pulses, state -> FINISH.
- FINISH (1 cycle):
  - reader_resetn=0, router=0, vectors zeroed.
  - pointer = (g+1) mod 4; state -> IDLE.
- Minimum gap between a completion pulse and the next ack is 1 cycle (FINISH), then 1 IDLE cycle.
- A requester's req still high after its done or error is a new request; it loses to others under round-robin.
- A req bit that drops before grant is simply not granted; no ack.
- i_wire_enable low during LAUNCH or RUN has no effect on the current job.
- Reset mid-job:
  - the reader is immediately forced back into reset;
  - no done or error pulse is issued and the job is lost;
  - the requester must re-request.
- o_wire_error_type keeps its value through successful jobs and clears only on reset.

Decomposition:
- Package painterengine_gpu_dma_pkg holds:
  - the FSM encodings;
  - the reader error codes: OK 0, ROUTER 1, ADDRESS 2, ADDR_TIMEOUT 3, DATA_TIMEOUT 4, PROTOCOL 5;
  - the scheduler error code WATCHDOG 6.
- Sub-module painterengine_gpu_rr_arbiter4: combinational 4-way round-robin picker (req, pointer -> one-hot grant, index, valid).

Test Plan:
- Single request on req[1], address 0x1000, length 16; reader model asserts done 20 cycles after release -> ack[1] one cycle after the request; router 4'b0010 and address slot 1 = 0x1000 stable from LAUNCH to FINISH; reader_resetn low for exactly 2 cycles before release; done[1] one pulse; busy low afterwards.
- req=4'b1111 held, each requester dropping its req after its ack -> acks in order 0,1,2,3; then re-assert req[0] and req[3] with pointer at 0 -> grant 0 then 3.
- req[2], address 0x1002; reader model raises error type 2 -> error[2] pulse, o_wire_error_type=2, no done pulse.
- WATCHDOG_WIDTH=8; reader model never responds -> error[g] exactly 256 cycles after RUN entry; error_type=6; reader_resetn driven low in FINISH.
- Reader model asserts done and error in the same cycle -> only error[g] pulses, error_type follows reader_error_type.
- Async reset asserted in RUN -> reader_resetn, router and busy are 0 immediately; no done or error pulse; after release a pending req[3] is granted first (pointer 0, only requester).
